// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor.
//   bp_state_e : predictor FSM states (table sweep, normal operation)
//   weak_nt    : weakly-not-taken counter value for a given counter width
//   sat_inc    : increment that sticks at max_v
//   sat_dec    : decrement that sticks at zero
package bp_pkg;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  function automatic int weak_nt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int sat_inc(input int v, input int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  function automatic int sat_dec(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/bp_gshare_predictor_if.sv
// Predict/update bus of the gshare predictor.
//   master : fetch/resolve side (drives pred_* requests and upd_* resolutions)
//   slave  : predictor side (drives ready, prediction, pred_ptr, success flags,
//            ghr and statistics counters)
interface bp_gshare_predictor_if #(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int STAT_W = 16
);
  logic              ready;
  logic              pred_valid;
  logic [IDX_W-1:0]  pred_index;
  logic              prediction;
  logic [IDX_W-1:0]  pred_ptr;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_ptr;
  logic              upd_outcome;
  logic              upd_pred;
  logic              success;
  logic              success_valid;
  logic              mispredict;
  logic [HIST_W-1:0] ghr;
  logic [STAT_W-1:0] stat_upd_cnt;
  logic [STAT_W-1:0] stat_hit_cnt;

  modport master (
    input  ready, prediction, pred_ptr, success, success_valid, mispredict,
           ghr, stat_upd_cnt, stat_hit_cnt,
    output pred_valid, pred_index, upd_valid, upd_ptr, upd_outcome, upd_pred
  );

  modport slave (
    output ready, prediction, pred_ptr, success, success_valid, mispredict,
           ghr, stat_upd_cnt, stat_hit_cnt,
    input  pred_valid, pred_index, upd_valid, upd_ptr, upd_outcome, upd_pred
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// One pattern-history-table entry: CTR_W-bit saturating counter.
//   clk      : clock
//   load     : write load_val (table initialisation), highest priority
//   load_val : value written on load
//   inc/dec  : saturating step up / down
//   msb      : counter MSB = taken prediction
// The table is rewritten by the predictor's sweep after every reset, so the
// counter itself carries no reset.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic             msb
);

  localparam int CTR_MAX = (1 << CTR_W) - 1;

  logic [CTR_W-1:0] ctr_reg;

  always_ff @(posedge clk) begin
    if (load) begin
      ctr_reg <= load_val;
    end else if (inc) begin
      ctr_reg <= CTR_W'(sat_inc(int'(ctr_reg), CTR_MAX));
    end else if (dec) begin
      ctr_reg <= CTR_W'(sat_dec(int'(ctr_reg)));
    end
  end

  assign msb = ctr_reg[CTR_W-1];

endmodule

// File: rtl/bp_gshare_predictor.sv
// Gshare branch predictor: PHT of saturating counters indexed by
// branch index XOR zero-extended global history.
//   clk   : clock
//   reset : synchronous, active-high; restarts the table sweep
//   bus   : slave side of bp_gshare_predictor_if (predict request/response,
//           update/resolution, success flags, ghr, statistics)
// After reset the FSM writes one entry per cycle with weakly-not-taken, then
// accepts requests (ready=1). Predictions are registered (latency 1) and read
// the table and history as they were before any same-cycle update.
// Optional feature: define PRED_STATS_EN to get saturating counts of accepted
// updates and successful updates; otherwise both outputs are tied to zero.
module bp_gshare_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bp_gshare_predictor_if.slave  bus
);

  localparam int PHT_D = 1 << IDX_W;
  localparam logic [0:0] ST_INIT = 1'(BP_INIT);
  localparam logic [0:0] ST_RUN  = 1'(BP_RUN);
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_nt(CTR_W));

  logic [0:0]        state_reg;
  logic [IDX_W-1:0]  sweep_reg;
  logic [HIST_W-1:0] ghr_reg;
  logic [HIST_W-1:0] ghr_next;
  logic              prediction_reg;
  logic [IDX_W-1:0]  pred_ptr_reg;
  logic              success_reg;
  logic              success_valid_reg;

  logic              running;
  logic              pred_fire;
  logic              upd_fire;
  logic [IDX_W-1:0]  pred_ptr_next;
  logic [PHT_D-1:0]  msb_vec;

  assign running       = (state_reg == ST_RUN);
  assign pred_fire     = running & bus.pred_valid;
  assign upd_fire      = running & bus.upd_valid;
  assign pred_ptr_next = bus.pred_index ^ IDX_W'(ghr_reg);

  // History shift; a 1-bit history simply holds the latest outcome.
  generate
    if (HIST_W == 1) begin : g_ghr_one
      assign ghr_next = bus.upd_outcome;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr_reg[HIST_W-2:0], bus.upd_outcome};
    end
  endgenerate

  // Pattern history table. The sweep owns the write port during INIT; in RUN
  // only the entry addressed by upd_ptr moves.
  generate
    for (genvar gi = 0; gi < PHT_D; gi++) begin : g_pht
      logic hit;
      assign hit = upd_fire && (bus.upd_ptr == IDX_W'(gi));
      bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
        .clk      (clk),
        .load     (!running && (sweep_reg == IDX_W'(gi))),
        .load_val (WEAK_NT),
        .inc      (hit & bus.upd_outcome),
        .dec      (hit & ~bus.upd_outcome),
        .msb      (msb_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_INIT;
      sweep_reg         <= '0;
      ghr_reg           <= '0;
      prediction_reg    <= 1'b0;
      pred_ptr_reg      <= '0;
      success_reg       <= 1'b0;
      success_valid_reg <= 1'b0;
    end else begin
      if (!running) begin
        sweep_reg <= sweep_reg + IDX_W'(1);
        if (sweep_reg == {IDX_W{1'b1}}) begin
          state_reg <= ST_RUN;
        end
      end
      if (pred_fire) begin
        prediction_reg <= msb_vec[pred_ptr_next];
        pred_ptr_reg   <= pred_ptr_next;
      end
      if (upd_fire) begin
        ghr_reg <= ghr_next;
      end
      success_valid_reg <= upd_fire;
      success_reg       <= upd_fire && (bus.upd_pred == bus.upd_outcome);
    end
  end

  assign bus.ready         = running;
  assign bus.prediction    = prediction_reg;
  assign bus.pred_ptr      = pred_ptr_reg;
  assign bus.ghr           = ghr_reg;
  assign bus.success       = success_reg;
  assign bus.success_valid = success_valid_reg;
  assign bus.mispredict    = success_valid_reg & ~success_reg;

`ifdef PRED_STATS_EN
  logic [STAT_W-1:0] stat_upd_reg;
  logic [STAT_W-1:0] stat_hit_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_reg <= '0;
      stat_hit_reg <= '0;
    end else if (upd_fire) begin
      if (stat_upd_reg != {STAT_W{1'b1}}) begin
        stat_upd_reg <= stat_upd_reg + STAT_W'(1);
      end
      if ((bus.upd_pred == bus.upd_outcome) && (stat_hit_reg != {STAT_W{1'b1}})) begin
        stat_hit_reg <= stat_hit_reg + STAT_W'(1);
      end
    end
  end

  assign bus.stat_upd_cnt = stat_upd_reg;
  assign bus.stat_hit_cnt = stat_hit_reg;
`else
  assign bus.stat_upd_cnt = {STAT_W{1'b0}};
  assign bus.stat_hit_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Bench for bp_gshare_predictor: directed vectors with hand-computed values
// plus a cycle-by-cycle reference model of the predictor's rules.
module tb_bp_gshare_predictor;

  localparam int IDX_W  = 4;
  localparam int HIST_W = 4;
  localparam int CTR_W  = 2;
  localparam int STAT_W = 16;
  localparam int DEPTH  = 1 << IDX_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_gshare_predictor_if #(.IDX_W(IDX_W), .HIST_W(HIST_W), .STAT_W(STAT_W)) bus_if ();

  bp_gshare_predictor #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pht [DEPTH];
  int m_ghr = 0;
  int m_init_left = 0;
  bit m_pred = 0;
  int m_ptr = 0;
  bit m_sv = 0;
  bit m_succ = 0;
  int m_upd = 0;
  int m_hit = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    int ptr;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_pht[i] = (1 << (CTR_W - 1)) - 1;
      m_ghr = 0; m_init_left = DEPTH; m_pred = 0; m_ptr = 0;
      m_sv = 0; m_succ = 0; m_upd = 0; m_hit = 0;
      chk_en = 1;
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_sv = 0; m_succ = 0;
    end else begin
      // prediction uses table and history from before this cycle's update
      if (bus_if.pred_valid) begin
        ptr = int'(bus_if.pred_index) ^ m_ghr;
        m_pred = (m_pht[ptr] >= (1 << (CTR_W - 1)));
        m_ptr = ptr;
      end
      m_sv = bus_if.upd_valid;
      m_succ = bus_if.upd_valid && (bus_if.upd_pred == bus_if.upd_outcome);
      if (bus_if.upd_valid) begin
        ptr = int'(bus_if.upd_ptr);
        if (bus_if.upd_outcome) m_pht[ptr] = (m_pht[ptr] + 1 > (1 << CTR_W) - 1) ? (1 << CTR_W) - 1 : m_pht[ptr] + 1;
        else                    m_pht[ptr] = (m_pht[ptr] - 1 < 0) ? 0 : m_pht[ptr] - 1;
        m_ghr = ((m_ghr * 2) + int'(bus_if.upd_outcome)) % (1 << HIST_W);
        if (m_upd < (1 << STAT_W) - 1) m_upd++;
        if (m_succ && m_hit < (1 << STAT_W) - 1) m_hit++;
      end
    end
  end

  always @(negedge clk) begin
    int e_upd;
    int e_hit;
    if (chk_en) begin
`ifdef PRED_STATS_EN
      e_upd = m_upd; e_hit = m_hit;
`else
      e_upd = 0; e_hit = 0;
`endif
      chk("m_ready", bus_if.ready, (m_init_left == 0));
      chk("m_prediction", bus_if.prediction, m_pred);
      chk("m_pred_ptr", bus_if.pred_ptr, m_ptr);
      chk("m_success_valid", bus_if.success_valid, m_sv);
      if (m_sv) chk("m_success", bus_if.success, m_succ);
      chk("m_mispredict", bus_if.mispredict, m_sv & ~m_succ);
      chk("m_ghr", bus_if.ghr, m_ghr);
      chk("m_stat_upd", bus_if.stat_upd_cnt, e_upd);
      chk("m_stat_hit", bus_if.stat_hit_cnt, e_hit);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit pv, input logic [3:0] pidx, input bit uv,
                       input logic [3:0] uptr, input bit uout, input bit upred);
    bus_if.pred_valid  = pv;
    bus_if.pred_index  = pidx;
    bus_if.upd_valid   = uv;
    bus_if.upd_ptr     = uptr;
    bus_if.upd_outcome = uout;
    bus_if.upd_pred    = upred;
    @(negedge clk);
  endtask

  // Called at the negedge right after the last reset edge.
  task automatic init_wait(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk({tag, "_ready_low"}, bus_if.ready, 0);
      chk({tag, "_pred_held"}, bus_if.prediction, 0);
      chk({tag, "_ptr_held"}, bus_if.pred_ptr, 0);
      @(negedge clk);
    end
    chk({tag, "_ready_high"}, bus_if.ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p_ptr;
    logic       p_pred;
    bit         a;
    int         upd_no;
    int         late;
    int         s_upd0;
    int         s_hit0;

    bus_if.pred_valid = 0; bus_if.pred_index = 0; bus_if.upd_valid = 0;
    bus_if.upd_ptr = 0; bus_if.upd_outcome = 0; bus_if.upd_pred = 0;
    repeat (3) @(negedge clk);

    // 1: sweep length, requests ignored during INIT
    reset = 0;
    bus_if.pred_valid = 1; bus_if.pred_index = 4'd3;
    bus_if.upd_valid = 1; bus_if.upd_ptr = 4'd3; bus_if.upd_outcome = 1;
    init_wait("t1");
    chk("t1_ghr_untouched", bus_if.ghr, 0);

    // 2: first predict / update on pointer 3
    drive(1, 4'd3, 0, 4'd0, 0, 0);
    chk("t2_ptr", bus_if.pred_ptr, 3);
    chk("t2_pred", bus_if.prediction, 0);
    p_ptr = bus_if.pred_ptr; p_pred = bus_if.prediction;
    drive(0, 4'd0, 1, p_ptr, 1, p_pred);
    chk("t2_sv", bus_if.success_valid, 1);
    chk("t2_mis", bus_if.mispredict, 1);
    chk("t2_ghr", bus_if.ghr, 1);
    drive(1, 4'd2, 0, 4'd0, 0, 0);          // 2 ^ ghr 1 -> ptr 3
    chk("t2_ptr2", bus_if.pred_ptr, 3);
    chk("t2_pred2", bus_if.prediction, 1);
    chk("t2_sv_idle", bus_if.success_valid, 0);

    // 3: saturation on pointer 5
    for (int i = 0; i < 5; i++) drive(0, 4'd0, 1, 4'd5, 1, 0);
    chk("t3_ghr_ones", bus_if.ghr, 15);
    drive(0, 4'd0, 1, 4'd5, 0, 1);
    chk("t3_ghr_a", bus_if.ghr, 14);
    chk("t3_mis", bus_if.mispredict, 1);
    drive(1, 4'd11, 0, 4'd0, 0, 0);         // 11 ^ 14 -> ptr 5, ctr 2
    chk("t3_ptr_a", bus_if.pred_ptr, 5);
    chk("t3_pred_a", bus_if.prediction, 1);
    drive(0, 4'd0, 1, 4'd5, 0, 1);
    chk("t3_ghr_b", bus_if.ghr, 12);
    drive(1, 4'd9, 0, 4'd0, 0, 0);          // 9 ^ 12 -> ptr 5, ctr 1
    chk("t3_ptr_b", bus_if.pred_ptr, 5);
    chk("t3_pred_b", bus_if.prediction, 0);

    // 5: same-cycle predict and update on pointer 6 (ctr 1)
    drive(1, 4'd10, 1, 4'd6, 1, 0);         // 10 ^ 12 -> ptr 6
    chk("t5_ptr", bus_if.pred_ptr, 6);
    chk("t5_pred_old", bus_if.prediction, 0);
    chk("t5_ghr", bus_if.ghr, 9);
    drive(1, 4'd15, 0, 4'd0, 0, 0);         // 15 ^ 9 -> ptr 6, ctr 2
    chk("t5_ptr2", bus_if.pred_ptr, 6);
    chk("t5_pred_new", bus_if.prediction, 1);

    // 4: alternating branch interleaved with always-taken branch
    s_upd0 = int'(bus_if.stat_upd_cnt); s_hit0 = int'(bus_if.stat_hit_cnt);
    upd_no = 0; late = 0; a = 0;
    for (int k = 0; k < 1000; k++) begin
      drive(1, 4'd3, 0, 4'd0, 0, 0);
      p_ptr = bus_if.pred_ptr; p_pred = bus_if.prediction;
      drive(0, 4'd0, 1, p_ptr, a, p_pred);
      upd_no++;
      if (upd_no > 64 && bus_if.mispredict) late++;
      drive(1, 4'd4, 0, 4'd0, 0, 0);
      p_ptr = bus_if.pred_ptr; p_pred = bus_if.prediction;
      drive(0, 4'd0, 1, p_ptr, 1, p_pred);
      upd_no++;
      if (upd_no > 64 && bus_if.mispredict) late++;
      a = !a;
    end
    chk("t4_late_mispredicts", late, 0);
`ifdef PRED_STATS_EN
    chk("t4_stat_upd", int'(bus_if.stat_upd_cnt) - s_upd0, 2000);
    chk("t4_stat_hit_ge_1936", (int'(bus_if.stat_hit_cnt) - s_hit0) >= 1936, 1);
`else
    chk("t4_stat_upd_tied", bus_if.stat_upd_cnt, 0);
    chk("t4_stat_hit_tied", bus_if.stat_hit_cnt, 0);
`endif

    // 6: one-cycle reset during RUN, with an update offered on that edge
    reset = 1;
    drive(1, 4'd3, 1, 4'd14, 1, 1);
    reset = 0;
    bus_if.pred_valid = 0; bus_if.upd_valid = 0;
    chk("t6_ghr", bus_if.ghr, 0);
    chk("t6_sv", bus_if.success_valid, 0);
    chk("t6_stat_upd", bus_if.stat_upd_cnt, 0);
    chk("t6_stat_hit", bus_if.stat_hit_cnt, 0);
    init_wait("t6");
    drive(1, 4'd14, 0, 4'd0, 0, 0);         // ptr 14 was trained taken before reset
    chk("t6_ptr", bus_if.pred_ptr, 14);
    chk("t6_pred_weak", bus_if.prediction, 0);
    drive(0, 4'd0, 1, 4'd14, 1, 0);
    drive(1, 4'd15, 0, 4'd0, 0, 0);         // 15 ^ ghr 1 -> ptr 14, ctr 2
    chk("t6_ptr2", bus_if.pred_ptr, 14);
    chk("t6_pred_after", bus_if.prediction, 1);
    drive(0, 4'd0, 0, 4'd0, 0, 0);
    drive(0, 4'd0, 0, 4'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
